// File: rtl/l2_response_receiver_pkg.sv
// rtl/l2_response_receiver_pkg.sv - shared L2 response bus defines and receiver constants
package l2_response_receiver_pkg;

    localparam int CORE_ID_WIDTH         = 4;
    localparam int L2_REQ_ID_WIDTH       = 4;
    localparam int CACHE_LINE_BYTES      = 64;
    localparam int CACHE_LINE_BITS       = CACHE_LINE_BYTES * 8;
    localparam int CACHE_LINE_ADDR_WIDTH = 32 - $clog2(CACHE_LINE_BYTES);

    typedef logic [CORE_ID_WIDTH-1:0]         core_id_t;
    typedef logic [L2_REQ_ID_WIDTH-1:0]       l2_req_id_t;
    typedef logic [CACHE_LINE_BITS-1:0]       cache_line_data_t;
    typedef logic [CACHE_LINE_ADDR_WIDTH-1:0] cache_line_address_t;

    typedef enum logic {
        CT_ICACHE = 1'b0,
        CT_DCACHE = 1'b1
    } cache_type_t;

    typedef enum logic [2:0] {
        L2RSP_LOAD_ACK        = 3'd0,
        L2RSP_STORE_ACK       = 3'd1,
        L2RSP_FLUSH_ACK       = 3'd2,
        L2RSP_IINVALIDATE_ACK = 3'd3,
        L2RSP_DINVALIDATE_ACK = 3'd4
    } l2rsp_packet_type_t;

    typedef struct packed {
        core_id_t            core;
        l2_req_id_t          id;
        l2rsp_packet_type_t  packet_type;
        cache_type_t         cache_type;
        logic                status;
        cache_line_address_t address;
        cache_line_data_t    data;
    } l2rsp_packet_t;

    // One pending-table entry per possible request id on the bus
    localparam int L2_PENDING = 2 ** $bits(l2_req_id_t);

endpackage

// File: rtl/l2_response_receiver_pending_table.sv
// rtl/l2_response_receiver_pending_table.sv - per-id waiting-thread bit table with collision merge
module l2_pending_table #(
    parameter int ENTRIES = 16,
    parameter int THREADS = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       set_en,
    input  logic [$clog2(ENTRIES)-1:0] set_id,
    input  logic [$clog2(THREADS)-1:0] set_thread,
    input  logic                       clr_en,
    input  logic [$clog2(ENTRIES)-1:0] clr_id,
    output logic [THREADS-1:0]         clr_mask
);

    logic [THREADS-1:0] pending_q [ENTRIES];
    logic [THREADS-1:0] pending_d [ENTRIES];
    logic [THREADS-1:0] set_bit;
    logic               collide;

    assign set_bit = THREADS'(1) << set_thread;
    assign collide = set_en && clr_en && (set_id == clr_id);

    // A thread registering in the very cycle its id is dispatched is woken with the rest
    assign clr_mask = pending_q[clr_id] | (collide ? set_bit : '0);

    // Apply the set first, then the clear, so a colliding alloc leaves the entry empty
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            pending_d[i] = pending_q[i];
        end
        if (set_en) begin
            pending_d[set_id] = pending_d[set_id] | set_bit;
        end
        if (clr_en) begin
            pending_d[clr_id] = '0;
        end
    end

    // Table storage; reset empties every entry
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pending_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                pending_q[i] <= pending_d[i];
            end
        end
    end

endmodule

// File: rtl/l2_response_receiver.sv
// rtl/l2_response_receiver.sv - core-side L2 response filter, pending tracker and dispatcher
module l2_response_receiver
    import l2_response_receiver_pkg::*;
#(
    parameter int CORE_ID = 0,
    parameter int THREADS = 4,
    parameter int PENDING = L2_PENDING
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       l2_response_valid,
    input  l2rsp_packet_t              l2_response,
    input  logic                       alloc_valid,
    input  logic [$clog2(PENDING)-1:0] alloc_id,
    input  logic [$clog2(THREADS)-1:0] alloc_thread,
    output logic                       fill_en,
    output cache_type_t                fill_cache_type,
    output cache_line_address_t        fill_address,
    output cache_line_data_t           fill_data,
    output logic                       store_done,
    output logic                       store_status,
    output logic                       inval_en,
    output logic                       flush_done,
    output logic [THREADS-1:0]         wake_mask,
    output logic                       unexpected_response
);

    localparam int ID_W = $clog2(PENDING);

    // Stage 1 capture registers
    logic                s1_valid_q;
    logic                s1_valid_d;
    logic [ID_W-1:0]     s1_id_q;
    l2rsp_packet_type_t  s1_type_q;
    cache_type_t         s1_ctype_q;
    logic                s1_status_q;
    cache_line_address_t s1_addr_q;
    cache_line_data_t    s1_data_q;

    // Stage 2 output registers
    logic                fill_en_q, fill_en_d;
    logic                store_done_q, store_done_d;
    logic                inval_en_q, inval_en_d;
    logic                flush_done_q, flush_done_d;
    logic [THREADS-1:0]  wake_mask_q, wake_mask_d;
    logic                unexpected_q, unexpected_d;
    cache_type_t         fill_cache_type_q, fill_cache_type_d;
    cache_line_address_t fill_address_q;
    cache_line_data_t    fill_data_q;
    logic                store_status_q;

    logic [THREADS-1:0]  table_mask;

    assign s1_valid_d = l2_response_valid && (l2_response.core == core_id_t'(CORE_ID));

    // Stage 1 valid: only responses addressed to this core enter the pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // Stage 1 payload: data path only, qualified by s1_valid_q
    always_ff @(posedge clk) begin
        if (s1_valid_d) begin
            s1_id_q     <= ID_W'(l2_response.id);
            s1_type_q   <= l2_response.packet_type;
            s1_ctype_q  <= l2_response.cache_type;
            s1_status_q <= l2_response.status;
            s1_addr_q   <= l2_response.address;
            s1_data_q   <= l2_response.data;
        end
    end

    l2_pending_table #(
        .ENTRIES (PENDING),
        .THREADS (THREADS)
    ) u_pending_table (
        .clk        (clk),
        .resetn     (reset),
        .set_en     (alloc_valid),
        .set_id     (alloc_id),
        .set_thread (alloc_thread),
        .clr_en     (s1_valid_q),
        .clr_id     (s1_id_q),
        .clr_mask   (table_mask)
    );

    // Stage 2 decode: map the captured packet type onto the L1 side pulses
    always_comb begin
        fill_en_d         = 1'b0;
        store_done_d      = 1'b0;
        inval_en_d        = 1'b0;
        flush_done_d      = 1'b0;
        fill_cache_type_d = s1_ctype_q;
        wake_mask_d       = '0;
        unexpected_d      = 1'b0;
        if (s1_valid_q) begin
            wake_mask_d  = table_mask;
            unexpected_d = (table_mask == '0);
            case (s1_type_q)
                L2RSP_LOAD_ACK: begin
                    fill_en_d = 1'b1;
                end
                L2RSP_STORE_ACK: begin
                    store_done_d = 1'b1;
                    // Write-through store data refreshes the resident D-line
                    fill_en_d    = (s1_ctype_q == CT_DCACHE);
                end
                L2RSP_FLUSH_ACK: begin
                    flush_done_d = 1'b1;
                end
                L2RSP_DINVALIDATE_ACK: begin
                    inval_en_d        = 1'b1;
                    fill_cache_type_d = CT_DCACHE;
                end
                L2RSP_IINVALIDATE_ACK: begin
                    inval_en_d        = 1'b1;
                    fill_cache_type_d = CT_ICACHE;
                end
                default: begin
                end
            endcase
        end
    end

    // Stage 2 control pulses; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_en_q    <= 1'b0;
            store_done_q <= 1'b0;
            inval_en_q   <= 1'b0;
            flush_done_q <= 1'b0;
            wake_mask_q  <= '0;
            unexpected_q <= 1'b0;
        end else begin
            fill_en_q    <= fill_en_d;
            store_done_q <= store_done_d;
            inval_en_q   <= inval_en_d;
            flush_done_q <= flush_done_d;
            wake_mask_q  <= wake_mask_d;
            unexpected_q <= unexpected_d;
        end
    end

    // Stage 2 data path; only meaningful alongside a control pulse
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            fill_cache_type_q <= fill_cache_type_d;
            fill_address_q    <= s1_addr_q;
            fill_data_q       <= s1_data_q;
            store_status_q    <= s1_status_q;
        end
    end

    assign fill_en             = fill_en_q;
    assign fill_cache_type     = fill_cache_type_q;
    assign fill_address        = fill_address_q;
    assign fill_data           = fill_data_q;
    assign store_done          = store_done_q;
    assign store_status        = store_status_q;
    assign inval_en            = inval_en_q;
    assign flush_done          = flush_done_q;
    assign wake_mask           = wake_mask_q;
    assign unexpected_response = unexpected_q;

endmodule

// File: tb/tb_l2_response_receiver.sv
// tb/tb_l2_response_receiver.sv - scoreboard bench for l2_response_receiver
module tb_l2_response_receiver;
    import l2_response_receiver_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                l2_response_valid;
    l2rsp_packet_t       l2_response;
    logic                alloc_valid;
    logic [3:0]          alloc_id;
    logic [1:0]          alloc_thread;
    logic                fill_en;
    cache_type_t         fill_cache_type;
    cache_line_address_t fill_address;
    cache_line_data_t    fill_data;
    logic                store_done;
    logic                store_status;
    logic                inval_en;
    logic                flush_done;
    logic [3:0]          wake_mask;
    logic                unexpected_response;

    always #5 clk = ~clk;

    l2_response_receiver #(
        .CORE_ID (0),
        .THREADS (4),
        .PENDING (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .l2_response_valid   (l2_response_valid),
        .l2_response         (l2_response),
        .alloc_valid         (alloc_valid),
        .alloc_id            (alloc_id),
        .alloc_thread        (alloc_thread),
        .fill_en             (fill_en),
        .fill_cache_type     (fill_cache_type),
        .fill_address        (fill_address),
        .fill_data           (fill_data),
        .store_done          (store_done),
        .store_status        (store_status),
        .inval_en            (inval_en),
        .flush_done          (flush_done),
        .wake_mask           (wake_mask),
        .unexpected_response (unexpected_response)
    );

    typedef struct {
        int                  cyc;
        logic                fill;
        cache_type_t         ct;
        cache_line_address_t addr;
        cache_line_data_t    data;
        logic                sd;
        logic                ss;
        logic                inv;
        logic                fl;
        logic [3:0]          wake;
        logic                unexp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic l2rsp_packet_t mk(input logic [3:0] core, input logic [3:0] id,
                                         input l2rsp_packet_type_t t, input cache_type_t ct,
                                         input logic st, input cache_line_address_t a,
                                         input cache_line_data_t d);
        l2rsp_packet_t p;
        p.core        = core;
        p.id          = id;
        p.packet_type = t;
        p.cache_type  = ct;
        p.status      = st;
        p.address     = a;
        p.data        = d;
        return p;
    endfunction

    task automatic step(input logic rst_n, input logic rv, input l2rsp_packet_t p,
                        input logic av, input logic [3:0] aid, input logic [1:0] ath);
        @(posedge clk);
        #1;
        reset             = rst_n;
        l2_response_valid = rv;
        l2_response       = p;
        alloc_valid       = av;
        alloc_id          = aid;
        alloc_thread      = ath;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 4'd0, 2'd0);
    endtask

    task automatic alloc(input logic [3:0] id, input logic [1:0] th);
        step(1'b1, 1'b0, '0, 1'b1, id, th);
    endtask

    task automatic rsp(input l2rsp_packet_t p);
        step(1'b1, 1'b1, p, 1'b0, 4'd0, 2'd0);
    endtask

    // Called right after the response is driven; outputs are due two cycles later
    task automatic expect_out(input l2rsp_packet_t p, input logic [3:0] wake);
        exp_t e;
        e.cyc   = cyc + 2;
        e.sd    = (p.packet_type == L2RSP_STORE_ACK);
        e.fill  = (p.packet_type == L2RSP_LOAD_ACK) || (e.sd && p.cache_type == CT_DCACHE);
        e.inv   = (p.packet_type == L2RSP_DINVALIDATE_ACK) || (p.packet_type == L2RSP_IINVALIDATE_ACK);
        e.fl    = (p.packet_type == L2RSP_FLUSH_ACK);
        e.ct    = (p.packet_type == L2RSP_DINVALIDATE_ACK) ? CT_DCACHE :
                  (p.packet_type == L2RSP_IINVALIDATE_ACK) ? CT_ICACHE : p.cache_type;
        e.addr  = p.address;
        e.data  = p.data;
        e.ss    = p.status;
        e.wake  = wake;
        e.unexp = (wake == 4'b0000);
        sb.push_back(e);
    endtask

    // Output monitor: every cycle either matches the scoreboard head or is silent
    always @(negedge clk) begin : monitor
        logic any;
        exp_t e;
        if (mon_en) begin
            any = fill_en | store_done | inval_en | flush_done | (|wake_mask) | unexpected_response;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check_val("fill_en", fill_en, e.fill);
                check_val("store_done", store_done, e.sd);
                check_val("inval_en", inval_en, e.inv);
                check_val("flush_done", flush_done, e.fl);
                check_val("wake_mask", wake_mask, e.wake);
                check_val("unexpected_response", unexpected_response, e.unexp);
                if (e.fill || e.inv) check_val("fill_cache_type", fill_cache_type, e.ct);
                if (e.fill) begin
                    check_val("fill_address", fill_address, e.addr);
                    check_val("fill_data", fill_data, e.data);
                end
                if (e.sd) check_val("store_status", store_status, e.ss);
            end else begin
                check_val("quiet_cycle", any, 1'b0);
            end
        end
    end

    initial begin : stimulus
        l2rsp_packet_t    p;
        cache_line_data_t pat_a;
        cache_line_data_t pat_b;
        cache_line_data_t pat_c;
        pat_a = {16{32'hA5A5_5A5A}};
        pat_b = {16{32'h1234_5678}};
        pat_c = {16{32'hDEAD_BEEF}};

        reset             = 1'b0;
        l2_response_valid = 1'b0;
        l2_response       = '0;
        alloc_valid       = 1'b0;
        alloc_id          = 4'd0;
        alloc_thread      = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_fill_en", fill_en, 1'b0);
        check_val("reset_store_done", store_done, 1'b0);
        check_val("reset_inval_en", inval_en, 1'b0);
        check_val("reset_flush_done", flush_done, 1'b0);
        check_val("reset_wake_mask", wake_mask, 4'b0000);
        check_val("reset_unexpected", unexpected_response, 1'b0);
        mon_en = 1'b1;
        idle();

        // Load ack waking thread 1, then the same id again finds an empty entry
        alloc(4'd3, 2'd1);
        idle();
        p = mk(4'd0, 4'd3, L2RSP_LOAD_ACK, CT_DCACHE, 1'b0, 26'h100, pat_a);
        rsp(p); expect_out(p, 4'b0010);
        repeat (3) idle();
        p = mk(4'd0, 4'd3, L2RSP_LOAD_ACK, CT_ICACHE, 1'b0, 26'h104, pat_b);
        rsp(p); expect_out(p, 4'b0000);
        repeat (3) idle();

        // Core filter: foreign response neither outputs nor disturbs the table
        alloc(4'd6, 2'd0);
        p = mk(4'd1, 4'd6, L2RSP_LOAD_ACK, CT_DCACHE, 1'b0, 26'h180, pat_c);
        rsp(p);
        repeat (3) idle();
        p = mk(4'd0, 4'd6, L2RSP_FLUSH_ACK, CT_DCACHE, 1'b0, 26'h180, pat_c);
        rsp(p); expect_out(p, 4'b0001);
        repeat (3) idle();

        // Store sync failure on icache (no fill), then dcache write-through store, unexpected
        alloc(4'd5, 2'd3);
        idle();
        p = mk(4'd0, 4'd5, L2RSP_STORE_ACK, CT_ICACHE, 1'b0, 26'h200, pat_b);
        rsp(p); expect_out(p, 4'b1000);
        p = mk(4'd0, 4'd7, L2RSP_STORE_ACK, CT_DCACHE, 1'b1, 26'h208, pat_c);
        rsp(p); expect_out(p, 4'b0000);
        repeat (3) idle();

        // Same-id collision: alloc lands in the dispatch cycle of id 2
        alloc(4'd2, 2'd0);
        idle();
        p = mk(4'd0, 4'd2, L2RSP_LOAD_ACK, CT_DCACHE, 1'b0, 26'h300, pat_a);
        rsp(p); expect_out(p, 4'b0101);
        alloc(4'd2, 2'd2);
        repeat (2) idle();
        p = mk(4'd0, 4'd2, L2RSP_LOAD_ACK, CT_DCACHE, 1'b0, 26'h304, pat_b);
        rsp(p); expect_out(p, 4'b0000);
        repeat (3) idle();

        // Streaming: four back-to-back responses, only id 1 pending
        alloc(4'd1, 2'd3);
        idle();
        p = mk(4'd0, 4'd0, L2RSP_LOAD_ACK, CT_DCACHE, 1'b0, 26'h400, pat_a);
        rsp(p); expect_out(p, 4'b0000);
        p = mk(4'd0, 4'd1, L2RSP_FLUSH_ACK, CT_DCACHE, 1'b0, 26'h440, pat_b);
        rsp(p); expect_out(p, 4'b1000);
        p = mk(4'd0, 4'd2, L2RSP_DINVALIDATE_ACK, CT_ICACHE, 1'b0, 26'h480, pat_c);
        rsp(p); expect_out(p, 4'b0000);
        p = mk(4'd0, 4'd3, L2RSP_IINVALIDATE_ACK, CT_DCACHE, 1'b0, 26'h4C0, pat_a);
        rsp(p); expect_out(p, 4'b0000);
        repeat (3) idle();

        // Reset one cycle after capture: response and table contents are dropped
        alloc(4'd4, 2'd1);
        p = mk(4'd0, 4'd4, L2RSP_LOAD_ACK, CT_DCACHE, 1'b0, 26'h500, pat_c);
        rsp(p);
        step(1'b0, 1'b0, '0, 1'b1, 4'd9, 2'd0);
        idle();
        idle();
        p = mk(4'd0, 4'd4, L2RSP_LOAD_ACK, CT_DCACHE, 1'b0, 26'h504, pat_a);
        rsp(p); expect_out(p, 4'b0000);
        p = mk(4'd0, 4'd9, L2RSP_FLUSH_ACK, CT_DCACHE, 1'b0, 26'h508, pat_a);
        rsp(p); expect_out(p, 4'b0000);
        idle();
        alloc(4'd4, 2'd2);
        idle();
        p = mk(4'd0, 4'd4, L2RSP_LOAD_ACK, CT_ICACHE, 1'b0, 26'h50C, pat_b);
        rsp(p); expect_out(p, 4'b0100);
        repeat (4) idle();

        check_val("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
